// File: rtl/fifo_cbb_prefetch_pkg.sv
// Shared constants for the fifo_cbb prefetch buffer: upstream read latency modes and count width.
// No logic; latency n/a.
// Backpressure n/a.
package fifo_cbb_prefetch_pkg;

    localparam int LAT_AHEAD  = 0;
    localparam int LAT_NORMAL = 1;
    localparam int LAT_OREG   = 2;

    // pre_cnt must represent 0..PRE_DEPTH inclusive
    function automatic int pre_cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_cbb_prefetch_ram.sv
// Prefetch storage: PRE_DEPTH x FIFO_WIDTH register array, one write port, asynchronous read.
// Write lands on the rising edge; read is combinational.
// No backpressure; the caller guarantees it never overwrites a live entry.
module fifo_cbb_prefetch_ram #(
    parameter int FIFO_WIDTH = 8,
    parameter int PRE_DEPTH  = 4
) (
    input  logic                         clk_sys,
    input  logic                         wr_en,
    input  logic [$clog2(PRE_DEPTH)-1:0] wr_addr,
    input  logic [FIFO_WIDTH-1:0]        wr_dat,
    input  logic [$clog2(PRE_DEPTH)-1:0] rd_addr,
    output logic [FIFO_WIDTH-1:0]        rd_dat
);

    logic [FIFO_WIDTH-1:0] mem [PRE_DEPTH];

    always_ff @(posedge clk_sys) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/fifo_cbb_prefetch.sv
// Prefetches words from an upstream fifo_cbb into a small buffer with a registered head (rdata).
// First word appears RD_LATENCY+1 cycles after the upstream read; pops take effect next cycle.
// Upstream reads are credit-limited by stored + in-flight words; ren on empty is dropped and flagged.
module fifo_cbb_prefetch
    import fifo_cbb_prefetch_pkg::*;
#(
    parameter int FIFO_WIDTH = 8,
    parameter int PRE_DEPTH  = 4,
    parameter int RD_LATENCY = LAT_NORMAL
) (
    input  logic                                clk_sys,
    input  logic                                reset,
    input  logic                                fifo_empty,
    input  logic [FIFO_WIDTH-1:0]               fifo_rdata,
    output logic                                pre_fifo_ren,
    input  logic                                ren,
    output logic [FIFO_WIDTH-1:0]               rdata,
    output logic                                empty,
    output logic [pre_cnt_width(PRE_DEPTH)-1:0] pre_cnt,
    output logic                                ren_err
);

    localparam int CW = pre_cnt_width(PRE_DEPTH);
    localparam int PW = $clog2(PRE_DEPTH);

    logic [CW-1:0]         inflight;
    logic                  wr_vld;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         rd_nxt_ptr;
    logic [FIFO_WIDTH-1:0] nxt_dat;
    logic                  pop;
    logic [CW:0]           occupancy;

    generate
        if (RD_LATENCY == LAT_AHEAD) begin : g_ahead
            assign wr_vld   = pre_fifo_ren;
            assign inflight = '0;
        end else begin : g_lat
            logic [RD_LATENCY-1:0] lat_sr;

            always_ff @(posedge clk_sys) begin
                if (reset) begin
                    lat_sr <= '0;
                end else begin
                    lat_sr[0] <= pre_fifo_ren;
                    for (int i = 1; i < RD_LATENCY; i++) begin
                        lat_sr[i] <= lat_sr[i-1];
                    end
                end
            end

            always_comb begin
                inflight = '0;
                for (int i = 0; i < RD_LATENCY; i++) begin
                    inflight = inflight + CW'(lat_sr[i]);
                end
            end

            assign wr_vld = lat_sr[RD_LATENCY-1];
        end
    endgenerate

    // A pop in the same cycle is deliberately not credited back
    assign occupancy    = {1'b0, pre_cnt} + {1'b0, inflight};
    assign pre_fifo_ren = !reset && !fifo_empty && (occupancy < (CW+1)'(PRE_DEPTH));
    assign pop          = ren && !empty;
    assign rd_nxt_ptr   = rd_ptr + PW'(1);

    fifo_cbb_prefetch_ram #(
        .FIFO_WIDTH (FIFO_WIDTH),
        .PRE_DEPTH  (PRE_DEPTH)
    ) u_ram (
        .clk_sys (clk_sys),
        .wr_en   (wr_vld),
        .wr_addr (wr_ptr),
        .wr_dat  (fifo_rdata),
        .rd_addr (rd_nxt_ptr),
        .rd_dat  (nxt_dat)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pre_cnt <= '0;
            empty   <= 1'b1;
            rdata   <= '0;
            ren_err <= 1'b0;
        end else begin
            ren_err <= ren && empty;
            if (wr_vld) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_nxt_ptr;
            end
            case ({wr_vld, pop})
                2'b10: begin
                    pre_cnt <= pre_cnt + CW'(1);
                    empty   <= 1'b0;
                end
                2'b01: begin
                    pre_cnt <= pre_cnt - CW'(1);
                    empty   <= (pre_cnt == CW'(1));
                end
                default: ;
            endcase
            // With one entry left, the word arriving this cycle becomes the head directly
            if (pop) begin
                if (pre_cnt > CW'(1)) begin
                    rdata <= nxt_dat;
                end else if (wr_vld) begin
                    rdata <= fifo_rdata;
                end
            end else if (wr_vld && empty) begin
                rdata <= fifo_rdata;
            end
        end
    end

endmodule

// File: tb/tb_fifo_cbb_prefetch.sv
// Bench for fifo_cbb_prefetch: three instances (RD_LATENCY 0, 1, 2; PRE_DEPTH 4) fed by a
// behavioural upstream fifo_cbb model per instance, sharing one clock and reset.
module tb_fifo_cbb_prefetch;

    logic       clk_sys;
    logic       reset;
    logic       pre_fifo_ren [3];
    logic       ren          [3];
    logic [7:0] rdata        [3];
    logic       empty        [3];
    logic [2:0] pre_cnt      [3];
    logic       ren_err      [3];

    logic [7:0] up_data [3][256];
    int         up_wr   [3];

    int checks = 0;
    int errors = 0;

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    for (genvar g = 0; g < 3; g++) begin : g_inst
        int         up_rd = 0;
        logic [7:0] pipe0 = '0;
        logic [7:0] pipe1 = '0;
        logic       fifo_empty;
        logic [7:0] fifo_rdata;

        assign fifo_empty = (up_rd == up_wr[g]);
        assign fifo_rdata = (g == 0) ? up_data[g][up_rd] : ((g == 1) ? pipe0 : pipe1);

        // Upstream fifo_cbb: reset discards everything not yet read
        always @(posedge clk_sys) begin
            if (reset) begin
                up_rd <= up_wr[g];
            end else begin
                if (pre_fifo_ren[g]) begin
                    pipe0 <= up_data[g][up_rd];
                    up_rd <= up_rd + 1;
                end
                pipe1 <= pipe0;
            end
        end

        fifo_cbb_prefetch #(
            .FIFO_WIDTH (8),
            .PRE_DEPTH  (4),
            .RD_LATENCY (g)
        ) u_dut (
            .clk_sys      (clk_sys),
            .reset        (reset),
            .fifo_empty   (fifo_empty),
            .fifo_rdata   (fifo_rdata),
            .pre_fifo_ren (pre_fifo_ren[g]),
            .ren          (ren[g]),
            .rdata        (rdata[g]),
            .empty        (empty[g]),
            .pre_cnt      (pre_cnt[g]),
            .ren_err      (ren_err[g])
        );
    end

    typedef struct {
        logic       ren;
        logic       emp;
        int         cnt;
        logic       pren;
        logic [7:0] dat;
        logic       err;
    } vec_t;

    vec_t tv [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic load(input int g, input logic [7:0] w);
        up_data[g][up_wr[g]] = w;
        up_wr[g]++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int   seen;
        int   gaps;
        int   rerr;
        int   first_cyc;
        logic started;
        logic done;

        // Upstream A..E into the RD_LATENCY=1 instance, hold ren low, then drain and overpop
        tv[0]  = '{1'b0, 1'b1, 0, 1'b1, 8'h00, 1'b0};
        tv[1]  = '{1'b0, 1'b1, 0, 1'b1, 8'h00, 1'b0};
        tv[2]  = '{1'b0, 1'b0, 1, 1'b1, 8'hA0, 1'b0};
        tv[3]  = '{1'b0, 1'b0, 2, 1'b1, 8'hA0, 1'b0};
        tv[4]  = '{1'b0, 1'b0, 3, 1'b0, 8'hA0, 1'b0};
        tv[5]  = '{1'b0, 1'b0, 4, 1'b0, 8'hA0, 1'b0};
        tv[6]  = '{1'b1, 1'b0, 4, 1'b0, 8'hA0, 1'b0};
        tv[7]  = '{1'b0, 1'b0, 3, 1'b1, 8'hA1, 1'b0};
        tv[8]  = '{1'b0, 1'b0, 3, 1'b0, 8'hA1, 1'b0};
        tv[9]  = '{1'b1, 1'b0, 4, 1'b0, 8'hA1, 1'b0};
        tv[10] = '{1'b1, 1'b0, 3, 1'b0, 8'hA2, 1'b0};
        tv[11] = '{1'b1, 1'b0, 2, 1'b0, 8'hA3, 1'b0};
        tv[12] = '{1'b1, 1'b0, 1, 1'b0, 8'hA4, 1'b0};
        tv[13] = '{1'b1, 1'b1, 0, 1'b0, 8'hA4, 1'b0};
        tv[14] = '{1'b0, 1'b1, 0, 1'b0, 8'hA4, 1'b1};
        tv[15] = '{1'b0, 1'b1, 0, 1'b0, 8'hA4, 1'b0};

        reset = 1'b1;
        for (int g = 0; g < 3; g++) begin
            ren[g]   = 1'b0;
            up_wr[g] = 0;
        end

        // Reset state, and no upstream read while reset is high
        tick();
        load(1, 8'hEE);
        #1;
        chk("rst_pren_forced_low", 32'(pre_fifo_ren[1]), 32'd0);
        for (int g = 0; g < 3; g++) begin
            chk("rst_empty",   32'(empty[g]),   32'd1);
            chk("rst_pre_cnt", 32'(pre_cnt[g]), 32'd0);
            chk("rst_rdata",   32'(rdata[g]),   32'd0);
            chk("rst_ren_err", 32'(ren_err[g]), 32'd0);
        end
        tick();
        reset = 1'b0;
        tick();

        for (int w = 0; w < 5; w++) begin
            load(1, 8'(8'hA0 + w));
        end
        for (int i = 0; i < 16; i++) begin
            if (i > 0) tick();
            ren[1] = tv[i].ren;
            #1;
            chk("tbl_empty",   32'(empty[1]),        32'(tv[i].emp));
            chk("tbl_pre_cnt", 32'(pre_cnt[1]),      tv[i].cnt);
            chk("tbl_pren",    32'(pre_fifo_ren[1]), 32'(tv[i].pren));
            chk("tbl_rdata",   32'(rdata[1]),        32'(tv[i].dat));
            chk("tbl_ren_err", 32'(ren_err[1]),      32'(tv[i].err));
        end
        ren[1] = 1'b0;

        // RD_LATENCY=0: single word, popped in the cycle empty falls
        tick();
        load(0, 8'h5A);
        #1;
        chk("ahead_pren", 32'(pre_fifo_ren[0]), 32'd1);
        tick();
        chk("ahead_empty_fall", 32'(empty[0]),   32'd0);
        chk("ahead_rdata",      32'(rdata[0]),   32'h5A);
        chk("ahead_cnt1",       32'(pre_cnt[0]), 32'd1);
        ren[0] = 1'b1;
        #1;
        chk("ahead_pren_idle", 32'(pre_fifo_ren[0]), 32'd0);
        tick();
        ren[0] = 1'b0;
        chk("ahead_empty_after_pop", 32'(empty[0]),   32'd1);
        chk("ahead_rdata_hold",      32'(rdata[0]),   32'h5A);
        chk("ahead_cnt0",            32'(pre_cnt[0]), 32'd0);
        chk("ahead_no_ren_err",      32'(ren_err[0]), 32'd0);

        // pre_cnt==1 with a simultaneous write and pop
        load(0, 8'h11);
        #1;
        tick();
        chk("wp_cnt_before",   32'(pre_cnt[0]), 32'd1);
        chk("wp_rdata_before", 32'(rdata[0]),   32'h11);
        load(0, 8'h22);
        ren[0] = 1'b1;
        #1;
        chk("wp_pren", 32'(pre_fifo_ren[0]), 32'd1);
        tick();
        ren[0] = 1'b0;
        chk("wp_cnt_after",   32'(pre_cnt[0]), 32'd1);
        chk("wp_rdata_after", 32'(rdata[0]),   32'h22);
        chk("wp_empty_after", 32'(empty[0]),   32'd0);
        ren[0] = 1'b1;
        tick();
        ren[0] = 1'b0;
        chk("wp_drain_empty", 32'(empty[0]),   32'd1);
        chk("wp_drain_cnt",   32'(pre_cnt[0]), 32'd0);

        // RD_LATENCY=2: 100-word stream with ren held high once data appears
        tick();
        for (int w = 0; w < 100; w++) begin
            load(2, 8'(w));
        end
        seen      = 0;
        gaps      = 0;
        rerr      = 0;
        first_cyc = -1;
        started   = 1'b0;
        done      = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            if (cyc > 0) tick();
            #1;
            if (ren_err[2]) rerr++;
            if (!empty[2]) begin
                if (!started) begin
                    started   = 1'b1;
                    first_cyc = cyc;
                end
                chk("stream_data", 32'(rdata[2]), seen);
                ren[2] = (seen < 100);
                seen++;
            end else begin
                ren[2] = 1'b0;
                if (started && seen < 100) gaps++;
                if (seen >= 100) done = 1'b1;
            end
        end
        ren[2] = 1'b0;
        chk("stream_count",      seen,      32'd100);
        chk("stream_first_word", first_cyc, 32'd3);
        chk("stream_gaps",       gaps,      32'd0);
        chk("stream_ren_err",    rerr,      32'd0);

        // Reset with two reads in flight at RD_LATENCY=2
        tick();
        for (int w = 0; w < 5; w++) begin
            load(2, 8'(8'hC0 + w));
        end
        #1;
        chk("inflt_pren_c0", 32'(pre_fifo_ren[2]), 32'd1);
        tick();
        chk("inflt_pren_c1", 32'(pre_fifo_ren[2]), 32'd1);
        tick();
        reset = 1'b1;
        #1;
        chk("inflt_pren_in_reset", 32'(pre_fifo_ren[2]), 32'd0);
        tick();
        reset = 1'b0;
        chk("inflt_empty", 32'(empty[2]),   32'd1);
        chk("inflt_cnt",   32'(pre_cnt[2]), 32'd0);
        chk("inflt_rdata", 32'(rdata[2]),   32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("inflt_late_empty", 32'(empty[2]),        32'd1);
            chk("inflt_late_cnt",   32'(pre_cnt[2]),      32'd0);
            chk("inflt_late_pren",  32'(pre_fifo_ren[2]), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
